arb_muxn: RTL and testbench
===========================

# arb_muxn

Parametrised N-channel registered multiplexer with valid/ready handshakes on every input and the output. It selects one channel per cycle, either by an explicit select (fixed mode) or by round-robin arbitration (RR mode), and captures it into a one-entry output register. It replaces the combinational 4-way select muxes wherever several producers share one consumer, such as GPIO read-back or multiple units sharing a register-file write port, and the path needs back-pressure and fairness.

## Interface
- WIDTH, 32, data width per channel (1..64)
- NCH, 4, channel count (2..8)
- SELW, derived = clog2(NCH), select/channel-index width; not overridden
- clk  in  1  rising-edge clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SELW  channel index used in fixed mode
- in_valid  in  NCH  per-channel valid
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  NCH  per-channel ready; one-hot or zero
- out_valid  out  1  output register holds a word
- out_data  out  WIDTH  held word
- out_ch  out  SELW  source channel of held word
- out_ready  in  1  consumer accepts the word

## Operation
- Load enable: le = !out_valid || out_ready. The register accepts a new word in the same cycle the old one drains.
- Fixed mode:
  - Candidate is `sel`.
  - A grant is issued only if sel < NCH and in_valid[sel]=1.
  - sel ≥ NCH produces no grant and all in_ready=0.
- RR mode:
  - Candidate is the first channel with in_valid=1, scanning ptr+1, ptr+2, … with modulo-NCH wrap.
  - No valid channel means no grant.
- in_ready[g] = le && grant_valid && (g == grant). All other in_ready bits are 0.
- Transfer on channel g happens when in_valid[g] && in_ready[g]. At the clock edge:
  - out_data ← in_data[g]
  - out_ch ← g
  - out_valid ← 1
- A drain without a new transfer (out_valid && out_ready && !grant_valid) sets out_valid ← 0. out_data and out_ch keep their old values.
- ptr updates to g only on a transfer in RR mode. Fixed-mode transfers leave ptr unchanged.
- A mode change takes effect on the grant computed in the same cycle, since the grant is combinational from `mode`. ptr is retained across mode changes.
- While out_valid=1 and out_ready=0: out_data and out_ch are frozen and all in_ready=0.
- Width rules:
  - No arithmetic on data.
  - ptr wraps at NCH, not at 2^SELW. This matters when NCH is not a power of two: at NCH=5, ptr+1 from 4 is 0.

## Timing
- Reset values (asynchronous on rst_n low, held while low):
  - out_valid=0
  - out_data=0
  - out_ch=0
  - ptr=NCH-1, so channel 0 wins first after reset
  - in_ready=0 while in reset
- Latency is 1 cycle from transfer edge to out_valid/out_data.
- Throughput is 1 word/cycle when out_ready is held high.
- in_ready is combinational from in_valid, mode, sel, ptr, out_valid and out_ready. There is no combinational path from in_data to any output.
- Reset mid-operation discards the held word. No partial handshake survives reset.
- Fairness in RR mode: with every channel continuously valid and out_ready=1, each channel is granted exactly once every NCH cycles.

## Structure
- Shared package arb_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1
  - clog2 function used to derive SELW
- Sub-module rr_pick, combinational (parameter NCH):
  - Inputs: req[NCH], ptr[SELW].
  - Outputs: gnt_idx[SELW], gnt_vld.
  - Implemented as a rotate → priority-encode → un-rotate.
- Top level contains the fixed/RR candidate select, the load-enable logic, the output register and the ptr register.

## Test plan
- Reset, then RR mode, NCH=4, in_valid=4'b1111, out_ready=1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3; out_valid=1 from cycle 1 after the first edge.
- Fixed mode, sel=2, in_data[2]=32'hDEAD_BEEF, in_valid=4'b0100 → in_ready=4'b0100; next cycle out_data=DEAD_BEEF, out_ch=2. Setting sel=3 with in_valid[3]=0 → in_ready=0000, and out_valid drops after the drain.
- Back-pressure: out_valid=1, out_ready=0 for 5 cycles with all channels valid → in_ready=0000 and out_data stable throughout. Raising out_ready → the held word drains and the next RR channel loads in the same cycle.
- NCH=5 RR with only channels 4 and 0 valid → out_ch alternates 4,0,4,0, checking the modulo-5 wrap. Fixed mode with sel=5..7 → no grant.
- Mode switch: in RR mode after granting channel 1, switch to fixed mode with sel=3 for 2 transfers, then back to RR → the next RR grant is channel 2, because ptr is retained.
- Assert rst_n low asynchronously mid-clock while out_valid=1 → out_valid, out_data and out_ch become 0 immediately; after release the first RR grant is channel 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the arb_muxn registered multiplexer and its arbiter.
package arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2, minimum 1 so a 2-channel mux still gets a 1-bit index.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_muxn_rr_pick.sv
// Round-robin pick: first requester after ptr, scanning with modulo-NCH wrap.
// Built as rotate -> priority-encode -> un-rotate so the wrap point is NCH,
// not 2^SELW.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_vld
);

    logic [NCH-1:0]  rot;
    logic [SELW-1:0] pe_idx;

    // Rotate so that position 0 of rot is channel ptr+1.
    always_comb begin
        rot = '0;
        for (int k = 0; k < NCH; k++) begin
            logic [SELW-1:0] src;
            src    = SELW'((int'(ptr) + 1 + k) % NCH);
            rot[k] = req[src];
        end
    end

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        pe_idx  = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (!gnt_vld && rot[k]) begin
                gnt_vld = 1'b1;
                pe_idx  = SELW'(k);
            end
        end
    end

    // Un-rotate back to an absolute channel index.
    always_comb begin
        gnt_idx = SELW'((int'(ptr) + 1 + int'(pe_idx)) % NCH);
    end

endmodule

// File: rtl/arb_muxn.sv
// N-channel registered mux with valid/ready on every input and the output.
// Fixed-select or round-robin grant feeds a one-entry output register that
// can reload in the same cycle it drains.
module arb_muxn
    import arb_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NCH   = 4,
    localparam int SELW  = clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    input  logic                 out_ready
);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] rr_idx;
    logic            rr_vld;
    logic            fx_vld;
    logic [SELW-1:0] grant;
    logic            grant_valid;
    logic            le;
    logic            xfer;

    rr_pick #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr_pick (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    // Fixed-mode candidate; an out-of-range select never grants.
    always_comb begin
        fx_vld = 1'b0;
        if (int'(sel) < NCH) begin
            fx_vld = in_valid[sel];
        end
    end

    // Grant select, load enable and one-hot ready. Ready is forced low in
    // reset so no handshake can complete while the register is cleared.
    always_comb begin
        grant       = (mode == MODE_RR) ? rr_idx : sel;
        grant_valid = (mode == MODE_RR) ? rr_vld : fx_vld;
        le          = !out_valid || out_ready;
        xfer        = le && grant_valid;
        in_ready    = (xfer && rst_n) ? (NCH'(1) << grant) : '0;
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SELW'(NCH - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
            out_ch    <= grant;
            if (mode == MODE_RR) begin
                ptr <= grant;
            end
        end else if (le) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_muxn.sv
// Bench for arb_muxn: a 4-channel and a 5-channel instance share stimulus;
// a behavioural model predicts grants and a scoreboard carries the words.
module tb_arb_muxn;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mode;
    logic [2:0]   sel;
    logic [7:0]   iv;
    logic         out_ready;
    logic [31:0]  idata [8];
    logic [127:0] data4;
    logic [159:0] data5;

    logic [3:0]   ready4;
    logic         ov4;
    logic [31:0]  od4;
    logic [1:0]   och4;
    logic [4:0]   ready5;
    logic         ov5;
    logic [31:0]  od5;
    logic [2:0]   och5;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] data;
        int          ch;
    } sb_t;
    sb_t sb[$];

    bit          m_valid [2];
    int          m_ptr   [2];
    logic [31:0] m_data  [2];
    int          m_ch    [2];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) data4[i*32 +: 32] = idata[i];
        for (int i = 0; i < 5; i++) data5[i*32 +: 32] = idata[i];
    end

    arb_muxn #(.WIDTH(32), .NCH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel[1:0]),
        .in_valid(iv[3:0]), .in_data(data4), .in_ready(ready4),
        .out_valid(ov4), .out_data(od4), .out_ch(och4), .out_ready(out_ready)
    );

    arb_muxn #(.WIDTH(32), .NCH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(iv[4:0]), .in_data(data5), .in_ready(ready5),
        .out_valid(ov5), .out_data(od5), .out_ch(och5), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out();
        chk("ov4",  {63'd0, ov4},  {63'd0, m_valid[0]});
        chk("od4",  {32'd0, od4},  {32'd0, m_data[0]});
        chk("och4", {62'd0, och4}, 64'(m_ch[0]));
        chk("ov5",  {63'd0, ov5},  {63'd0, m_valid[1]});
        chk("od5",  {32'd0, od5},  {32'd0, m_data[1]});
        chk("och5", {61'd0, och5}, 64'(m_ch[1]));
    endtask

    task automatic model_reset();
        m_valid[0] = 0; m_ptr[0] = 3; m_data[0] = '0; m_ch[0] = 0;
        m_valid[1] = 0; m_ptr[1] = 4; m_data[1] = '0; m_ch[1] = 0;
        sb.delete();
    endtask

    // One clock: predict grants, check ready, clock, check the register.
    task automatic step();
        bit xf [2];
        sb_t e;
        #1;
        for (int d = 0; d < 2; d++) begin
            int n, s, gi;
            bit le, gv;
            logic [7:0] er;
            n  = (d == 1) ? 5 : 4;
            s  = (d == 1) ? int'(sel) : int'(sel[1:0]);
            le = !m_valid[d] || out_ready;
            gv = 0;
            gi = 0;
            if (mode) begin
                for (int k = 1; k <= n; k++) begin
                    int c;
                    c = (m_ptr[d] + k) % n;
                    if (!gv && iv[c]) begin
                        gv = 1;
                        gi = c;
                    end
                end
            end else if (s < n && iv[s]) begin
                gv = 1;
                gi = s;
            end
            xf[d] = le && gv;
            er    = xf[d] ? (8'd1 << gi) : 8'd0;
            if (d == 0) chk("ready4", {60'd0, ready4}, {56'd0, er});
            else        chk("ready5", {59'd0, ready5}, {56'd0, er});
            if (xf[d]) begin
                e.data = idata[gi];
                e.ch   = gi;
                sb.push_back(e);
                m_valid[d] = 1;
                if (mode) m_ptr[d] = gi;
            end else if (le) begin
                m_valid[d] = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (xf[d]) begin
                e = sb.pop_front();
                m_data[d] = e.data;
                m_ch[d]   = e.ch;
            end
        end
        chk_out();
    endtask

    task automatic new_data();
        for (int i = 0; i < 8; i++) idata[i] = $urandom();
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b1; sel = '0; iv = '0; out_ready = 1'b1;
        new_data();
        model_reset();
        #12;
        iv = 8'hFF;
        #1;
        chk_out();
        chk("ready4_rst", {60'd0, ready4}, 64'd0);
        chk("ready5_rst", {59'd0, ready5}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin fairness, all four channels valid.
        iv = 8'h0F;
        for (int k = 0; k < 8; k++) begin
            new_data();
            step();
            chk("rr_seq4", {62'd0, och4}, 64'(k % 4));
            chk("rr_ov4", {63'd0, ov4}, 64'd1);
        end

        // Fixed select of channel 2, then an idle channel 3.
        mode = 1'b0; sel = 3'd2; iv = 8'h04;
        new_data();
        idata[2] = 32'hDEAD_BEEF;
        step();
        chk("fix_data", {32'd0, od4}, 64'hDEAD_BEEF);
        chk("fix_ch", {62'd0, och4}, 64'd2);
        sel = 3'd3;
        step();
        chk("fix_drain", {63'd0, ov4}, 64'd0);

        // Back-pressure: hold for five cycles, then drain and reload together.
        mode = 1'b1; iv = 8'h0F; new_data();
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            new_data();
            step();
        end
        out_ready = 1'b1;
        step();

        // Five-channel wrap: only channels 4 and 0 request.
        iv = 8'h11;
        for (int k = 0; k < 4; k++) begin
            new_data();
            step();
            chk("wrap5", {61'd0, och5}, (k % 2 == 0) ? 64'd4 : 64'd0);
        end

        // Out-of-range selects on the five-channel instance never grant.
        mode = 1'b0; iv = 8'hFF;
        for (int s = 5; s < 8; s++) begin
            sel = 3'(s);
            new_data();
            step();
            chk("oor5", {63'd0, ov5}, 64'd0);
        end

        // Mode switch keeps the round-robin pointer.
        mode = 1'b1; iv = 8'h02; new_data();
        step();
        chk("ms_g1", {62'd0, och4}, 64'd1);
        mode = 1'b0; sel = 3'd3; iv = 8'h08;
        step();
        step();
        mode = 1'b1; iv = 8'h0F; new_data();
        step();
        chk("ms_rr2", {62'd0, och4}, 64'd2);

        // Asynchronous reset between edges while a word is held.
        out_ready = 1'b0;
        #2;
        chk("pre_rst_ov4", {63'd0, ov4}, 64'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_out();
        chk("ready4_ar", {60'd0, ready4}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        new_data();
        step();
        chk("post_rst_ch0", {62'd0, och4}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
